// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
//
// One radix-2 step per cycle: shift-add for MULT/MULTU and restoring
// division for DIV/DIVU. Signed operations work on operand magnitudes and
// fix the signs when the result is written. Every operation takes WIDTH
// cycles in RUN. The result is written to hi_reg/lo_reg on the last RUN edge,
// and done pulses for the cycle after that edge.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   sig_start    request a new operation (accepted only in IDLE)
//   sig_op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a/src_b  operands (dividend a, divisor b)
//   sig_cancel   abort the in-flight operation, blocks a start in IDLE
//   sig_mthi/lo  direct writes of write_data into HI/LO (IDLE only)
//   write_data   data for sig_mthi/sig_mtlo
//   busy         high while an operation is running
//   done         one-cycle completion pulse
//   div_by_zero  qualifies done for a divide by zero
//   hi_reg/lo_reg architectural HI and LO
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_start,
  input  logic [1:0]       sig_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             sig_cancel,
  input  logic             sig_mthi,
  input  logic             sig_mtlo,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_reg,
  output logic [WIDTH-1:0] lo_reg
);

  // The counter is wide enough to hold WIDTH, so it never wraps.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic             run_div;    // latched op is a divide
  logic             neg_q;      // negate the product, or the quotient
  logic             neg_r;      // negate the remainder (the dividend was negative)
  logic [WIDTH-1:0] work_hi;    // partial product high half, or remainder
  logic [WIDTH-1:0] work_lo;    // multiplier being shifted out, or quotient being shifted in
  logic [WIDTH-1:0] mag_b;      // multiplicand, or divisor magnitude
  logic [WIDTH-1:0] a_raw;      // dividend as given, returned in HI on divide by zero

  logic             start_ok;
  logic             last;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] div_hi_nx, div_lo_nx;
  logic [2*WIDTH-1:0] prod_mag, prod_fin;
  logic [WIDTH-1:0] quot_fin, rem_fin;

  assign busy     = (state == RUN);
  assign start_ok = (state == IDLE) && sig_start && !sig_cancel;
  assign last     = (cnt == CW'(WIDTH - 1));

  // Magnitude and sign capture at start. Only MULT and DIV (op[0]==0) are signed.
  // The most-negative value maps to itself. Read as unsigned, that is its magnitude.
  always_comb begin
    a_neg    = ~sig_op[0] & src_a[WIDTH-1];
    b_neg    = ~sig_op[0] & src_b[WIDTH-1];
    mag_a_in = a_neg ? -src_a : src_a;
    mag_b_in = b_neg ? -src_b : src_b;
  end

  // One iteration of each algorithm. Both are always computed, and run_div picks one.
  always_comb begin
    mul_sum   = {1'b0, work_hi} + {1'b0, (work_lo[0] ? mag_b : {WIDTH{1'b0}})};
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], work_lo[WIDTH-1:1]};

    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    if (!div_diff[WIDTH]) begin
      div_hi_nx = div_diff[WIDTH-1:0];
      div_lo_nx = {work_lo[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_nx = div_shift[WIDTH-1:0];
      div_lo_nx = {work_lo[WIDTH-2:0], 1'b0};
    end

    prod_mag = {mul_hi_nx, mul_lo_nx};
    prod_fin = neg_q ? -prod_mag : prod_mag;
    quot_fin = neg_q ? -div_lo_nx : div_lo_nx;
    rem_fin  = neg_r ? -div_hi_nx : div_hi_nx;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. Cancel wins over completion on the final cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = RUN;
      RUN:  if (sig_cancel || last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      run_div     <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      work_hi     <= '0;
      work_lo     <= '0;
      mag_b       <= '0;
      a_raw       <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == IDLE) begin
        // A move issued together with a start lands now. The result overwrites it later.
        if (sig_mthi) hi_reg <= write_data;
        if (sig_mtlo) lo_reg <= write_data;
        if (start_ok) begin
          cnt     <= '0;
          run_div <= sig_op[1];
          neg_q   <= a_neg ^ b_neg;
          neg_r   <= a_neg;
          work_hi <= '0;
          work_lo <= mag_a_in;
          mag_b   <= mag_b_in;
          a_raw   <= src_a;
        end
      end else if (!sig_cancel) begin
        cnt     <= cnt + 1'b1;
        work_hi <= run_div ? div_hi_nx : mul_hi_nx;
        work_lo <= run_div ? div_lo_nx : mul_lo_nx;
        if (last) begin
          done <= 1'b1;
          if (!run_div) begin
            {hi_reg, lo_reg} <= prod_fin;
          end else if (mag_b == '0) begin
            hi_reg      <= a_raw;
            lo_reg      <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi_reg <= rem_fin;
            lo_reg <= quot_fin;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit. It uses a 32-bit instance for the main tests and
// an 8-bit instance for the small-width divide case. Known vectors come from
// a table. Random operations are checked against a plain-arithmetic model.
// Some hand-written sequences cover cancel, moves and reset.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sig_start, sig_cancel, sig_mthi, sig_mtlo;
  logic [1:0]  sig_op;
  logic [31:0] src_a, src_b, write_data, hi_reg, lo_reg;
  logic        busy, done, div_by_zero;

  logic        s8_start;
  logic [1:0]  s8_op;
  logic [7:0]  s8_a, s8_b, s8_hi, s8_lo;
  logic        s8_busy, s8_done, s8_dbz;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .sig_start(sig_start), .sig_op(sig_op),
    .src_a(src_a), .src_b(src_b), .sig_cancel(sig_cancel), .sig_mthi(sig_mthi),
    .sig_mtlo(sig_mtlo), .write_data(write_data), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi_reg(hi_reg), .lo_reg(lo_reg)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .sig_start(s8_start), .sig_op(s8_op),
    .src_a(s8_a), .src_b(s8_b), .sig_cancel(1'b0), .sig_mthi(1'b0),
    .sig_mtlo(1'b0), .write_data(8'h00), .busy(s8_busy), .done(s8_done),
    .div_by_zero(s8_dbz), .hi_reg(s8_hi), .lo_reg(s8_lo)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic on sign-extended / zero-extended operands.
  function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] hi,
                                output logic [31:0] lo, output logic dbz);
    longint mask, ua, ub, sa, sb, p, q, r;
    mask = (longint'(1) << w) - 1;
    ua = {32'b0, a} & mask;
    ub = {32'b0, b} & mask;
    sa = (ua > (mask >> 1)) ? ua - (mask + 1) : ua;
    sb = (ub > (mask >> 1)) ? ub - (mask + 1) : ub;
    dbz = 1'b0;
    p = 0; q = 0; r = 0;
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = ua * ub;
      2'b10: if (ub != 0) begin q = sa / sb; r = sa % sb; end
      default: if (ub != 0) begin q = ua / ub; r = ua % ub; end
    endcase
    if (!op[1]) begin
      hi = 32'((p >> w) & mask);
      lo = 32'(p & mask);
    end else if (ub == 0) begin
      hi = 32'(ua);
      lo = 32'(mask);
      dbz = 1'b1;
    end else begin
      hi = 32'(r & mask);
      lo = 32'(q & mask);
    end
  endfunction

  // Entered and left at a negedge. On return, the current cycle is the
  // done cycle, so calling again gives a back-to-back start.
  // poke>0 pulses a conflicting start during that busy cycle.
  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int poke, output int nbusy, output logic d, output logic z);
    sig_start = 1'b1; sig_op = op; src_a = a; src_b = b;
    @(negedge clk);
    sig_start = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 40) begin
      nbusy++;
      if (nbusy == poke) begin
        sig_start = 1'b1; sig_op = 2'b11; src_a = '1; src_b = 32'd1;
      end else sig_start = 1'b0;
      @(negedge clk);
    end
    sig_start = 1'b0;
    d = done;
    z = div_by_zero;
  endtask

  task automatic op32(input string name, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                      input logic edbz, input int poke);
    int nb; logic d, z;
    run32(op, a, b, poke, nb, d, z);
    $display("op32 %s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b busy=%0d",
             name, op, a, b, hi_reg, lo_reg, z, nb);
    check({name, ".busy_cycles"}, 64'(nb), 64'd32);
    check({name, ".done"}, {63'b0, d}, 64'd1);
    check({name, ".dbz"}, {63'b0, z}, {63'b0, edbz});
    check({name, ".hi"}, {32'b0, hi_reg}, {32'b0, ehi});
    check({name, ".lo"}, {32'b0, lo_reg}, {32'b0, elo});
  endtask

  task automatic op8(input string name, input logic [1:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] ehi, input logic [7:0] elo,
                     input logic edbz);
    int nb;
    s8_start = 1'b1; s8_op = op; s8_a = a; s8_b = b;
    @(negedge clk);
    s8_start = 1'b0;
    nb = 0;
    while (s8_busy && nb < 20) begin nb++; @(negedge clk); end
    $display("op8 %s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b busy=%0d",
             name, op, a, b, s8_hi, s8_lo, s8_dbz, nb);
    check({name, ".busy_cycles"}, 64'(nb), 64'd8);
    check({name, ".done"}, {63'b0, s8_done}, 64'd1);
    check({name, ".dbz"}, {63'b0, s8_dbz}, {63'b0, edbz});
    check({name, ".hi"}, {56'b0, s8_hi}, {56'b0, ehi});
    check({name, ".lo"}, {56'b0, s8_lo}, {56'b0, elo});
  endtask

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] ehi, elo, ra, rb;
    logic        ez, seen;
    logic [1:0]  rop;
    int          n;

    vecs[0] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[6] = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[7] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};

    sig_start = 0; sig_cancel = 0; sig_mthi = 0; sig_mtlo = 0;
    sig_op = 0; src_a = 0; src_b = 0; write_data = 0;
    s8_start = 0; s8_op = 0; s8_a = 0; s8_b = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("reset.busy", {63'b0, busy}, 64'd0);
    check("reset.done", {63'b0, done}, 64'd0);
    check("reset.dbz", {63'b0, div_by_zero}, 64'd0);
    check("reset.hi", {32'b0, hi_reg}, 64'd0);
    check("reset.lo", {32'b0, lo_reg}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // The first vector starts on the first edge after reset release.
    // The rest run back-to-back, each started in the done cycle.
    for (int i = 0; i < 10; i++)
      op32($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
           vecs[i].hi, vecs[i].lo, vecs[i].dbz, 0);

    // Direct moves: both together, then LO alone.
    sig_mthi = 1; sig_mtlo = 1; write_data = 32'hA5A5A5A5;
    @(negedge clk);
    sig_mthi = 0; sig_mtlo = 0;
    $display("move both -> hi=%h lo=%h", hi_reg, lo_reg);
    check("mv_both.hi", {32'b0, hi_reg}, 64'hA5A5A5A5);
    check("mv_both.lo", {32'b0, lo_reg}, 64'hA5A5A5A5);
    sig_mtlo = 1; write_data = 32'h12345678;
    @(negedge clk);
    sig_mtlo = 0;
    $display("move lo -> hi=%h lo=%h", hi_reg, lo_reg);
    check("mtlo.lo", {32'b0, lo_reg}, 64'h12345678);
    check("mtlo.hi", {32'b0, hi_reg}, 64'hA5A5A5A5);

    // Cancel in RUN cycle 10. An MTHI in cycle 5 must be ignored.
    sig_start = 1; sig_op = 2'b00; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk);
    sig_start = 0;
    repeat (4) @(negedge clk);
    sig_mthi = 1; write_data = 32'hDEADBEEF;
    @(negedge clk);
    sig_mthi = 0;
    repeat (4) @(negedge clk);
    check("cancel.busy_before", {63'b0, busy}, 64'd1);
    sig_cancel = 1;
    @(negedge clk);
    sig_cancel = 0;
    $display("cancel -> busy=%0b hi=%h lo=%h", busy, hi_reg, lo_reg);
    check("cancel.busy_after", {63'b0, busy}, 64'd0);
    check("cancel.lo", {32'b0, lo_reg}, 64'h12345678);
    check("cancel.hi", {32'b0, hi_reg}, 64'hA5A5A5A5);
    seen = 0;
    repeat (40) begin seen |= done; @(negedge clk); end
    check("cancel.no_done", {63'b0, seen}, 64'd0);

    // Cancel together with start in IDLE starts nothing.
    sig_cancel = 1; sig_start = 1; sig_op = 2'b01;
    @(negedge clk);
    sig_cancel = 0; sig_start = 0;
    $display("cancel+start idle -> busy=%0b", busy);
    check("cancel_start.busy", {63'b0, busy}, 64'd0);

    // A start pulsed during RUN must not disturb the running MULTU.
    op32("start_in_run", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 3);

    // A move issued with a start lands at E0. The result overwrites it later.
    sig_start = 1; sig_op = 2'b01; src_a = 32'd2; src_b = 32'd3;
    sig_mtlo = 1; write_data = 32'h0000CAFE;
    @(negedge clk);
    sig_start = 0; sig_mtlo = 0;
    check("mv_start.lo_e0", {32'b0, lo_reg}, 64'h0000CAFE);
    n = 1;
    while (busy && n < 40) begin n++; @(negedge clk); end
    $display("move+start -> hi=%h lo=%h done=%0b", hi_reg, lo_reg, done);
    check("mv_start.done", {63'b0, done}, 64'd1);
    check("mv_start.lo", {32'b0, lo_reg}, 64'd6);

    // Reset in RUN cycle 5: outputs clear without an edge, and no done follows.
    sig_start = 1; sig_op = 2'b11; src_a = 32'd1000; src_b = 32'd7;
    @(negedge clk);
    sig_start = 0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("reset in run -> busy=%0b done=%0b hi=%h lo=%h", busy, done, hi_reg, lo_reg);
    check("rst_run.busy", {63'b0, busy}, 64'd0);
    check("rst_run.lo", {32'b0, lo_reg}, 64'd0);
    check("rst_run.hi", {32'b0, hi_reg}, 64'd0);
    check("rst_run.done", {63'b0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin seen |= done; @(negedge clk); end
    check("rst_run.no_done", {63'b0, seen}, 64'd0);

    // Random 32-bit operations, with divide-by-zero and overflow cases biased in.
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom_range(3, 0));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(7, 0) == 0) rb = 32'd0;
      if ($urandom_range(15, 0) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if ($urandom_range(3, 0) == 0) rb = rb >> $urandom_range(31, 0);
      model(32, rop, ra, rb, ehi, elo, ez);
      op32($sformatf("rnd%0d", i), rop, ra, rb, ehi, elo, ez, 0);
    end

    // 8-bit instance
    op8("w8_div", 2'b10, 8'h80, 8'h03, 8'hFE, 8'hD6, 1'b0);
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(3, 0));
      ra = {24'b0, 8'($urandom)};
      rb = {24'b0, 8'($urandom)};
      if ($urandom_range(7, 0) == 0) rb = 32'd0;
      model(8, rop, ra, rb, ehi, elo, ez);
      op8($sformatf("w8_rnd%0d", i), rop, ra[7:0], rb[7:0], ehi[7:0], elo[7:0], ez);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
